// File: rtl/bin2bcd_seq_if.sv
// Conversion handshake and result bus for bin2bcd_seq.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank_mask;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, blank_mask, ovf);
  modport slave  (input start, bin, output busy, done, bcd, blank_mask, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow flag and leading-zero blanking mask for the 7-seg drivers.
module bin2bcd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  logic [3:0] adj;
  assign adj  = (d >= 4'd5) ? d + 4'd3 : d;
  assign q    = {adj[2:0], cin};
  assign cout = adj[3];
endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  bin2bcd_seq_if.slave  conv
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] MASK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       sr;
  logic [DIGITS-1:0][3:0] scratch, shifted, bcd_q;
  logic [DIGITS:0]        carry;
  logic                   ovf_acc, ovf_q, done_q;
  logic [DIGITS-1:0]      mask_q, mask_nxt;

  // Digit chain: shift-register MSB enters digit 0, top carry-out is lost
  // into the overflow accumulator.
  assign carry[0] = sr[WIDTH-1];
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bin2bcd_digit u_dig (
      .d    (scratch[k]),
      .cin  (carry[k]),
      .q    (shifted[k]),
      .cout (carry[k+1])
    );
  end

  always_comb begin
    logic z;
    mask_nxt = '0;
    z        = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z           = z & (scratch[k] == 4'd0);
      mask_nxt[k] = z;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (conv.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt     <= '0;
      sr      <= '0;
      scratch <= '0;
      ovf_acc <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      mask_q  <= MASK_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (conv.start) begin
          sr      <= conv.bin;
          scratch <= '0;
          ovf_acc <= 1'b0;
          cnt     <= CW'(WIDTH);
        end
        SHIFT: begin
          scratch <= shifted;
          sr      <= {sr[WIDTH-2:0], 1'b0};
          ovf_acc <= ovf_acc | carry[DIGITS];
          cnt     <= cnt - CW'(1);
        end
        FINISH: begin
          bcd_q  <= scratch;
          ovf_q  <= ovf_acc;
          mask_q <= mask_nxt;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign conv.busy       = (state != IDLE);
  assign conv.done       = done_q;
  assign conv.bcd        = bcd_q;
  assign conv.ovf        = ovf_q;
  assign conv.blank_mask = mask_q;
endmodule
